multibyte_uart_tx: RTL and testbench
====================================

Name: multibyte_uart_tx

Overview:
Parametrised successor to the word-to-byte UART transmitter. It accepts a word of up to WORD_BYTES bytes through a valid/ready handshake and sends a runtime-selected number of its low bytes as back-to-back UART frames. Byte order is selectable per transfer. Sits between the word-producing datapath and the board UART TX pin.

Parameters:
- WORD_BYTES, 4: maximum bytes per word; i_word width is 8*WORD_BYTES.
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud). Must be ≥2.
- PARITY_ODD, 0: parity sense; used only when the parity macro is defined.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- i_valid, in, 1: word offered.
- o_ready, out, 1: block can accept a word.
- i_word, in, 8*WORD_BYTES: payload.
- i_len, in, $clog2(WORD_BYTES+1): number of bytes to send.
- i_msb_first, in, 1: 1 = highest selected byte first; 0 = byte 0 first.
- o_serial, out, 1: UART line, idle high.
- o_busy, out, 1: a transfer is in progress.
- o_done, out, 1: one-cycle pulse when the transfer completes.
- o_byte_idx, out, $clog2(WORD_BYTES): index into i_word of the byte currently on the line.
- o_state, out, 3: current FSM state code, for debug.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is `reset`, asynchronous and active-high.
- Reset values: o_serial=1, o_busy=0, o_done=0, o_byte_idx=0, o_state=IDLE. o_ready=0 while reset is high.
- o_ready = (state==IDLE) && !reset.
- Accept: i_valid && o_ready at a rising edge. On that edge the block latches i_word, the effective length and i_msb_first; later input changes are ignored.
- Effective length N: i_len==0 or i_len>WORD_BYTES gives N=WORD_BYTES; otherwise N=i_len.
- FSM states: IDLE(0), START(1), DATA(2), PARITY(3), STOP(4).
- Transitions:
  - IDLE→START on accept.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits, or DATA→PARITY when the parity macro is defined.
  - PARITY→STOP after CLKS_PER_BIT cycles.
  - STOP→START if bytes remain; STOP→IDLE after the last byte.
- Line timing:
  - o_serial is registered. It goes low on the accept edge, so the start bit occupies the CLKS_PER_BIT cycles after that edge.
  - Data bits go out LSB first, each held CLKS_PER_BIT cycles.
  - Stop bit = 1.
  - No idle gap between the bytes of one transfer.
- Byte order:
  - i_msb_first=0: byte index 0,1,…,N-1.
  - i_msb_first=1: byte index N-1,…,0.
  - o_byte_idx updates at each START entry.
- Completion:
  - On the edge that ends the last stop bit: state→IDLE, o_done=1 for exactly one cycle, o_busy→0.
  - Total latency from accept edge to o_done edge = N·F·CLKS_PER_BIT, where F=10 (11 with parity).
- Back-to-back: a word accepted in the o_done cycle starts its start bit at once, with zero idle bits.
- i_valid while busy: ignored. No buffering and no error flag.
- Reset mid-transfer: o_serial returns to 1 immediately (asynchronously) and the frame is truncated. Everything returns to reset values; o_done is not pulsed.
- Counters: bit counter 0..7 and byte counter 0..WORD_BYTES-1. The baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state entry.

Optional Feature:
MULTIBYTE_UART_TX_PARITY_EN
- Defined: each frame inserts a PARITY bit after bit 7. The bit is even parity when PARITY_ODD=0 and odd parity when PARITY_ODD=1. Frame length F=11.
- Undefined: PARITY is never entered and the frame is 8N1, F=10. The PARITY state code stays reserved so o_state encoding is unchanged.

Decomposition:
- Package multibyte_uart_tx_pkg holds:
  - the state codes IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - the constants UART_DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module: uart_baud_tick. It is a restartable counter that emits a one-cycle tick every CLKS_PER_BIT cycles, with inputs clock, reset and restart.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and WORD_BYTES=4 unless stated.
1. i_word=32'h00ff90af, i_len=0, i_msb_first=0 → bytes af,90,ff,00 on the line; o_busy high throughout; o_done pulses once, 160 cycles after the accept edge.
2. Same word with i_msb_first=1 → bytes 00,ff,90,af; o_byte_idx sequence 3,2,1,0.
3. i_word=32'h000000cd, i_len=1 → a single frame. Line bits are 0,1,0,1,1,0,0,1,1,1, each held 4 cycles; o_done 40 cycles after accept.
4. Hold i_valid through a transfer while changing i_word mid-transfer → o_ready=0 while busy and the original bytes are sent unchanged. The new word is accepted in the o_done cycle, and its start bit begins with no idle gap.
5. Assert reset in the middle of the DATA state of byte 2 → o_serial=1 and o_state=0 without waiting for a clock edge; no o_done pulse. After release, o_ready=1 and a new 1-byte transfer of 0x55 completes correctly.
6. With MULTIBYTE_UART_TX_PARITY_EN defined, send 0xcd (five ones) → parity bit 1 when PARITY_ODD=0 and 0 when PARITY_ODD=1. The frame is 11 bits and o_done comes 44 cycles after accept.

Source files
------------

// File: rtl/multibyte_uart_tx_pkg.sv
// Shared types and constants for the multibyte UART transmitter.
// Holds FSM state codes and UART framing constants.
package multibyte_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

endpackage

// File: rtl/multibyte_uart_tx_baud.sv
// uart_baud_tick: restartable bit-period counter.
// Ports: clock, reset (async high), restart (zero count), o_tick (last cycle of a bit).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || o_tick) cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multibyte_uart_tx.sv
// Word-to-bytes UART transmitter: sends the low N bytes of a word as 8N1 frames.
// Ports: clock/reset, i_valid/o_ready handshake, i_word/i_len/i_msb_first payload,
// o_serial line, o_busy, o_done pulse, o_byte_idx and o_state for debug.
// Optional macro MULTIBYTE_UART_TX_PARITY_EN adds a parity bit (sense PARITY_ODD).
module multibyte_uart_tx
  import multibyte_uart_tx_pkg::*;
#(
  parameter int WORD_BYTES   = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_ODD   = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [8*WORD_BYTES-1:0]           i_word,
  input  logic [$clog2(WORD_BYTES+1)-1:0]   i_len,
  input  logic                              i_msb_first,
  output logic                              o_serial,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [$clog2(WORD_BYTES)-1:0]     o_byte_idx,
  output logic [2:0]                        o_state
);

  localparam int LW = $clog2(WORD_BYTES + 1);
  localparam int IW = $clog2(WORD_BYTES);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  state_e                  state_q, state_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    msb_q, msb_d;
  logic [2:0]              bit_q, bit_d;
  logic                    serial_q, serial_d;
  logic                    done_q, done_d;
  logic                    tick;
  logic                    restart;
  logic [IW-1:0]           eff_last;
  logic [7:0]              cur_byte;
  logic                    par_bit;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .o_tick (tick)
  );

  // Zero or oversized length means a full word.
  always_comb begin
    eff_last = IW'(WORD_BYTES - 1);
    if (i_len != '0 && i_len <= LW'(WORD_BYTES))
      eff_last = IW'(i_len - LW'(1));
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    msb_d   = msb_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = START;
          word_d  = i_word;
          last_d  = eff_last;
          msb_d   = i_msb_first;
          cnt_d   = '0;
          idx_d   = i_msb_first ? eff_last : '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
`ifdef MULTIBYTE_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            cnt_d   = cnt_q + IW'(1);
            idx_d   = msb_q ? idx_q - IW'(1) : idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value is derived from the next state so o_serial is registered
  // yet changes on the same edge as the state.
  assign cur_byte = word_d[{idx_d, 3'b000} +: 8];
  assign par_bit  = (^cur_byte) ^ (PARITY_ODD != 0);

  always_comb begin
    serial_d = STOP_BIT;
    unique case (state_d)
      START:   serial_d = START_BIT;
      DATA:    serial_d = cur_byte[bit_d];
      PARITY:  serial_d = par_bit;
      default: serial_d = STOP_BIT;
    endcase
  end

  // Every state entry starts a fresh bit period; IDLE holds the count at 0.
  assign restart = (state_d != state_q) || (state_q == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      word_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      msb_q    <= 1'b0;
      bit_q    <= '0;
      serial_q <= STOP_BIT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      msb_q    <= msb_d;
      bit_q    <= bit_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_ready    = (state_q == IDLE) && !reset;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_serial   = serial_q;
  assign o_byte_idx = idx_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_multibyte_uart_tx.sv
// Scoreboard bench for multibyte_uart_tx: a line receiver and a done
// monitor pop expectations pushed by the stimulus at each accept.
module tb_multibyte_uart_tx;

  localparam int WB   = 4;
  localparam int C    = 4;
  localparam int PODD = 0;
`ifdef MULTIBYTE_UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        msb = 1'b0;
  logic [31:0] word = '0;
  logic [2:0]  len = '0;
  logic        ready, ser, busy, done;
  logic [1:0]  bidx;
  logic [2:0]  st;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] b;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];

  multibyte_uart_tx #(
    .WORD_BYTES(WB),
    .CLKS_PER_BIT(C),
    .PARITY_ODD(PODD)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_word     (word),
    .i_len      (len),
    .i_msb_first(msb),
    .o_serial   (ser),
    .o_busy     (busy),
    .o_done     (done),
    .o_byte_idx (bidx),
    .o_state    (st)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // Line receiver: samples the middle of each bit after a falling edge.
  logic        rx_on = 1'b0;
  logic        rx_prev = 1'b1;
  int          rx_cnt = 0;
  int          rx_idx = 0;
  logic [10:0] rx_bits = '0;

  task automatic frame_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      flag("unexpected_frame");
      return;
    end
    e = exp_q.pop_front();
    chk("start_bit", 32'(rx_bits[0]), 32'(1'b0));
    chk("data_byte", 32'(rx_bits[8:1]), 32'(e.b));
`ifdef MULTIBYTE_UART_TX_PARITY_EN
    chk("parity_bit", 32'(rx_bits[9]), 32'((^e.b) ^ (PODD != 0)));
`endif
    chk("stop_bit", 32'(rx_bits[F-1]), 32'(1'b1));
    chk("byte_idx", rx_idx, e.idx);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rx_on   = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (!rx_on) begin
        if (rx_prev && !ser) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_on && (rx_cnt % C) == C / 2) begin
        rx_bits[rx_cnt / C] = ser;
        chk("busy_in_frame", 32'(busy), 32'(1'b1));
        if (rx_cnt / C == 0) rx_idx = int'(bidx);
        if (rx_cnt / C == F - 1) begin
          frame_check();
          rx_on = 1'b0;
        end
      end
      rx_prev = ser;
    end
  end

  // Completion monitor: one pulse per transfer at the modelled cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (done_q.size() == 0) flag("unexpected_done");
      else chk("done_cycle", cyc, done_q.pop_front());
      chk("busy_at_done", 32'(busy), 32'(1'b0));
    end
  end

  // Offer a word, wait for acceptance, push the modelled response.
  task automatic send(input logic [31:0] w, input logic [2:0] l,
                      input logic m, input bit keep, output int acc);
    bit ok;
    int n;
    int idx;
    ok  = 1'b0;
    acc = -1;
    word  = w;
    len   = l;
    msb   = m;
    valid = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      if (ready) begin
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        ok  = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!keep) valid = 1'b0;
    if (!ok) begin
      flag("accept_timeout");
      return;
    end
    n = (l == 0 || l > WB) ? WB : int'(l);
    for (int k = 0; k < n; k++) begin
      idx = m ? n - 1 - k : k;
      exp_q.push_back('{w[8*idx +: 8], idx});
    end
    done_q.push_back(acc + n * F * C);
  endtask

  int a1, a2, a3;
  bit hit;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(ser), 32'(1'b1));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_done", 32'(done), 32'(1'b0));
    chk("rst_idx", 32'(bidx), 32'(0));
    chk("rst_state", 32'(st), 32'(0));
    chk("rst_ready", 32'(ready), 32'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ready), 32'(1'b1));

    send(32'h00ff90af, 3'd0, 1'b0, 1'b0, a1);
    send(32'h00ff90af, 3'd0, 1'b1, 1'b0, a1);
    send(32'h000000cd, 3'd1, 1'b0, 1'b0, a1);

    // Hold valid and change the word mid-transfer.
    send(32'ha5c31e77, 3'd4, 1'b0, 1'b1, a1);
    repeat (50) @(negedge clk);
    word = 32'h3c4b5a69;
    chk("ready_busy", 32'(ready), 32'(1'b0));
    chk("busy_mid", 32'(busy), 32'(1'b1));
    send(32'h3c4b5a69, 3'd4, 1'b0, 1'b0, a2);
    chk("b2b_accept", a2, a1 + WB * F * C + 1);

    // Reset in the DATA state of byte index 2 (a zero byte, line low).
    send(32'h77001122, 3'd4, 1'b0, 1'b0, a3);
    hit = 1'b0;
    for (int t = 0; t < 2000 && !hit; t++) begin
      @(negedge clk);
      if (bidx == 2'd2 && st == 3'd2) hit = 1'b1;
    end
    if (!hit) flag("reach_data_timeout");
    repeat (2 * C) @(negedge clk);
    chk("pre_rst_line", 32'(ser), 32'(1'b0));
    #1 rst = 1'b1;
    #1;
    chk("async_serial", 32'(ser), 32'(1'b1));
    chk("async_state", 32'(st), 32'(0));
    chk("async_ready", 32'(ready), 32'(1'b0));
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_rel", 32'(ready), 32'(1'b1));
    @(negedge clk);
    send(32'h00000055, 3'd1, 1'b0, 1'b0, a3);

    for (int i = 0; i < 10; i++) begin
      send($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), a3);
    end
    valid = 1'b0;

    hit = 1'b0;
    for (int t = 0; t < 5000 && !hit; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && done_q.size() == 0) hit = 1'b1;
    end
    if (!hit) flag("drain_timeout");
    repeat (2 * C) @(negedge clk);
    chk("idle_line", 32'(ser), 32'(1'b1));
    chk("idle_state", 32'(st), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
